// File: rtl/ghist_checkpoint_ctrl_pkg.sv
// rtl/ghist_checkpoint_ctrl_pkg.sv - shared types and defaults for the global-history checkpoint controller
package ghist_checkpoint_ctrl_pkg;

  // Default history length and checkpoint depth for the 2-bit global-history predictor
  localparam int GHIST_WIDTH_HIST = 10;
  localparam int GHIST_DEPTH      = 8;
  localparam int GHIST_WIDTH_TAG  = $clog2(GHIST_DEPTH);

  // One checkpoint: the history that indexed the counters at fetch, plus the predicted direction
  typedef struct packed {
    logic [GHIST_WIDTH_HIST-1:0] hist;
    logic                        pred_taken;
  } ghist_ckpt_t;

  // Branch-resolution record; upd_tag carries the checkpoint tag handed out at fetch
  typedef struct packed {
    logic                       valid;
    logic                       taken;
    logic [GHIST_WIDTH_TAG-1:0] upd_tag;
  } br_info_t;

  // Source of the next speculative history when the normal fetch-time shift is overridden
  typedef enum logic [1:0] {
    REDIR_NONE    = 2'd0,
    REDIR_MISPRED = 2'd1,
    REDIR_FLUSH   = 2'd2
  } redirect_e;

endpackage

// File: rtl/ghist_ckpt_fifo.sv
// rtl/ghist_ckpt_fifo.sv - circular checkpoint buffer with push/pop and clear-to-pointer
module ghist_ckpt_fifo
  import ghist_checkpoint_ctrl_pkg::*;
#(
  parameter int WIDTH_HIST = GHIST_WIDTH_HIST,
  parameter int DEPTH      = GHIST_DEPTH,
  parameter int WIDTH_TAG  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  // push is only asserted by the controller when the buffer is not full
  input  logic                  push,
  input  logic [WIDTH_HIST-1:0] push_hist,
  input  logic                  push_pred,
  // pop is only asserted by the controller when the buffer is not empty
  input  logic                  pop,
  // clear empties the buffer and moves wptr to clear_ptr; rptr still follows pop
  input  logic                  clear,
  input  logic [WIDTH_TAG-1:0]  clear_ptr,
  output logic [WIDTH_HIST-1:0] rd_hist,
  output logic                  rd_pred,
  output logic [WIDTH_TAG-1:0]  wptr,
  output logic [WIDTH_TAG-1:0]  rptr,
  output logic                  full,
  output logic                  empty
);

  localparam int WIDTH_CNT = $clog2(DEPTH) + 1;

  logic [WIDTH_HIST-1:0] hist_mem [DEPTH];
  logic [DEPTH-1:0]      pred_mem;
  logic [WIDTH_CNT-1:0]  count;

  assign full    = (count == WIDTH_CNT'(DEPTH));
  assign empty   = (count == '0);
  assign rd_hist = hist_mem[rptr];
  assign rd_pred = pred_mem[rptr];

  // Entry storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (push) begin
      hist_mem[wptr] <= push_hist;
      pred_mem[wptr] <= push_pred;
    end
  end

  // Pointer and occupancy tracking; clear overrides push and the count update
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        rptr <= rptr + WIDTH_TAG'(1);
      end
      if (clear) begin
        wptr  <= clear_ptr;
        count <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + WIDTH_TAG'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + WIDTH_CNT'(1);
          2'b01:   count <= count - WIDTH_CNT'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/ghist_checkpoint_ctrl.sv
// rtl/ghist_checkpoint_ctrl.sv - speculative/committed global history with per-branch checkpoints
module ghist_checkpoint_ctrl
  import ghist_checkpoint_ctrl_pkg::*;
#(
  parameter int WIDTH_HIST = GHIST_WIDTH_HIST,
  parameter int DEPTH      = GHIST_DEPTH,
  parameter int WIDTH_TAG  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic                  fetch_pred_taken,
  output logic                  fetch_ready,
  output logic [WIDTH_TAG-1:0]  fetch_tag,
  output logic [WIDTH_HIST-1:0] spec_hist,
  input  logic                  upd_valid,
  input  logic [WIDTH_TAG-1:0]  upd_tag,
  input  logic                  upd_taken,
  output logic [WIDTH_HIST-1:0] upd_hist,
  output logic                  upd_mispred,
  input  logic                  flush,
  output logic                  err
);

  logic [WIDTH_HIST-1:0] commit_hist;
  logic [WIDTH_HIST-1:0] commit_next;
  logic [WIDTH_HIST-1:0] rd_hist;
  logic                  rd_pred;
  logic [WIDTH_TAG-1:0]  wptr;
  logic [WIDTH_TAG-1:0]  rptr;
  logic [WIDTH_TAG-1:0]  clear_ptr;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  mispred;
  logic                  fifo_push;
  logic                  fifo_clear;
  logic                  err_set;
  redirect_e             redirect;

  ghist_ckpt_fifo #(
    .WIDTH_HIST (WIDTH_HIST),
    .DEPTH      (DEPTH),
    .WIDTH_TAG  (WIDTH_TAG)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_hist (spec_hist),
    .push_pred (fetch_pred_taken),
    .pop       (pop_ok),
    .clear     (fifo_clear),
    .clear_ptr (clear_ptr),
    .rd_hist   (rd_hist),
    .rd_pred   (rd_pred),
    .wptr      (wptr),
    .rptr      (rptr),
    .full      (full),
    .empty     (empty)
  );

  // Handshake qualification, redirect selection and the post-pop committed history
  always_comb begin
    push_ok     = fetch_valid & ~full;
    pop_ok      = upd_valid & ~empty;
    mispred     = pop_ok & (upd_taken != rd_pred);
    fifo_clear  = flush | mispred;
    // Both flush and mispredict leave wptr just past the oldest surviving position,
    // i.e. the read pointer after this cycle's pop
    clear_ptr   = rptr + WIDTH_TAG'(pop_ok);
    fifo_push   = push_ok & ~fifo_clear;
    commit_next = pop_ok ? {commit_hist[WIDTH_HIST-2:0], upd_taken} : commit_hist;
    if (flush) begin
      redirect = REDIR_FLUSH;
    end else if (mispred) begin
      redirect = REDIR_MISPRED;
    end else begin
      redirect = REDIR_NONE;
    end
    err_set = (fetch_valid & full)
            | (upd_valid & empty)
            | (pop_ok & (upd_tag != rptr));
  end

  assign fetch_ready = ~full;
  assign fetch_tag   = wptr;
  assign upd_hist    = rd_hist;
  assign upd_mispred = mispred;

  // History registers and the sticky protocol error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_hist   <= '0;
      commit_hist <= '0;
      err         <= 1'b0;
    end else begin
      commit_hist <= commit_next;
      case (redirect)
        REDIR_FLUSH:   spec_hist <= commit_next;
        REDIR_MISPRED: spec_hist <= {rd_hist[WIDTH_HIST-2:0], upd_taken};
        default: begin
          if (push_ok) begin
            spec_hist <= {spec_hist[WIDTH_HIST-2:0], fetch_pred_taken};
          end
        end
      endcase
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
